pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter DWIDTH, default 32: width of one channel sample.
REQ-002 Parameter NUM_CHANNEL_IN, default 8: channels packed per output word.
REQ-003 Parameter WIDTH, default 56; HEIGHT, default 56: pixels per frame = WIDTH*HEIGHT.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-high reset (1 = reset asserted).
REQ-006 s_data  input  DWIDTH  one channel sample of the current pixel.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_sof  input  1  qualifies s_data as channel 0 of the first pixel of a frame.
REQ-009 s_ready  output  1  packer accepts s_data this cycle.
REQ-010 ff_wdata  output  NUM_CHANNEL_IN*DWIDTH  packed pixel to the input FIFO.
REQ-011 ff_wrreq  output  1  FIFO write strobe.
REQ-012 ff_full  input  1  FIFO full.
REQ-013 frame_done  output  1  one-cycle pulse, last pixel of a frame written.
REQ-014 sync_err  output  1  one-cycle pulse, partial pixel discarded by s_sof.

Function
REQ-015 Transfer: a sample is accepted on a rising edge where s_valid=1 and s_ready=1.
REQ-016 Lane order: k-th accepted sample of a pixel (k=0..NUM_CHANNEL_IN-1) lands in ff_wdata[(k+1)*DWIDTH-1 : k*DWIDTH].
REQ-017 Channel counter ch_cnt 0..NUM_CHANNEL_IN-1 increments per accepted sample, wraps to 0 after NUM_CHANNEL_IN-1.
REQ-018 Accepting the sample at ch_cnt=NUM_CHANNEL_IN-1 moves the assembled pixel into a one-entry output register, setting out_valid the next cycle.
REQ-019 ff_wrreq = out_valid AND NOT ff_full (combinational); out_valid clears after a write unless a new pixel is loaded in the same cycle.
REQ-020 ff_wdata holds stable while out_valid=1 and ff_full=1.
REQ-021 s_ready = NOT(ch_cnt=NUM_CHANNEL_IN-1 AND out_valid=1 AND ff_full=1); lanes 0..NUM_CHANNEL_IN-2 always accepted.
REQ-022 Simultaneous drain and load: write of old pixel and load of new pixel in one cycle; no bubble, no loss.
REQ-023 Throughput: one packed word per NUM_CHANNEL_IN cycles with continuous s_valid and ff_full=0; latency from last-lane acceptance to ff_wrreq = 1 cycle.
REQ-024 Pixel counter pix_cnt 0..WIDTH*HEIGHT-1 increments on each ff_wrreq; at WIDTH*HEIGHT-1 it wraps to 0 and frame_done pulses the following cycle.
REQ-025 s_sof accepted with ch_cnt=0: normal; pix_cnt forced to 0 (frame restart) if nonzero, no sync_err.
REQ-026 s_sof accepted with ch_cnt!=0: partial lanes discarded, sample stored in lane 0, ch_cnt=1, pix_cnt=0, sync_err pulses next cycle; pending out register unaffected and still written.
REQ-027 s_sof with s_valid=0 or s_ready=0 is ignored.
REQ-028 pix_cnt width = ceil(log2(WIDTH*HEIGHT)); no overflow beyond WIDTH*HEIGHT-1.

Reset
REQ-029 resetn=1 asynchronously clears ch_cnt, pix_cnt, out_valid, frame_done, sync_err; ff_wrreq=0, s_ready=1, ff_wdata=0.
REQ-030 Reset mid-pixel or with out_valid=1 discards the partial and pending pixel; no write after release.
REQ-031 First accepted sample after reset release goes to lane 0.

Verification
REQ-032 8 samples 0x1..0x8, s_valid=1, ff_full=0 -> one cycle after 8th, ff_wrreq=1, ff_wdata=0x00000008_..._00000001.
REQ-033 Pixel pending, ff_full=1 for 20 cycles, source keeps sending -> s_ready=0 at lane 7, ff_wdata stable, no write; ff_full=0 -> pending written, next pixel loaded same cycle, no sample lost.
REQ-034 Stream 3136 pixels (WIDTH=HEIGHT=56) -> exactly 3136 writes, frame_done single pulse one cycle after 3136th write, pix_cnt=0.
REQ-035 s_sof accepted at ch_cnt=5 -> sync_err pulse, next write holds sof sample in lane 0, pix_cnt=0.
REQ-036 resetn=1 asserted at ch_cnt=4 with out_valid=1 -> ff_wrreq=0 immediately; after release, next 8 samples form first word.
REQ-037 Random s_valid/ff_full, 10k cycles -> scoreboard: written words equal input samples grouped by 8 in order.

Source files
------------

// File: rtl/pixel_packer_if.sv
// Channel-sample stream in, packed-pixel FIFO write out, plus frame status pulses.
// master = source/sink side, slave = packer.
interface pixel_packer_if #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8
);
  logic [DWIDTH-1:0]                s_data;
  logic                             s_valid;
  logic                             s_sof;
  logic                             s_ready;
  logic [NUM_CHANNEL_IN*DWIDTH-1:0] ff_wdata;
  logic                             ff_wrreq;
  logic                             ff_full;
  logic                             frame_done;
  logic                             sync_err;

  modport master (
    output s_data, s_valid, s_sof, ff_full,
    input  s_ready, ff_wdata, ff_wrreq, frame_done, sync_err
  );

  modport slave (
    input  s_data, s_valid, s_sof, ff_full,
    output s_ready, ff_wdata, ff_wrreq, frame_done, sync_err
  );
endinterface

// File: rtl/pixel_packer.sv
// Packs NUM_CHANNEL_IN samples per pixel into a one-entry output register feeding a FIFO.
// Write strobe 1 cycle after the last lane; stalls only the last lane while a pixel waits on a full FIFO.
module pixel_packer #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8,
  parameter int WIDTH          = 56,
  parameter int HEIGHT         = 56
) (
  input logic           clk,
  input logic           resetn,
  pixel_packer_if.slave bus
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = (NUM_CHANNEL_IN > 1) ? $clog2(NUM_CHANNEL_IN) : 1;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNEL_IN - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(TOTAL - 1);

  logic [NUM_CHANNEL_IN-1:0][DWIDTH-1:0] lanes_q, lanes_d;
  logic [NUM_CHANNEL_IN-1:0][DWIDTH-1:0] out_q, out_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic          out_vld_q, out_vld_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;
  logic          s_ready, wr, acc, resync;

  always_comb begin
    s_ready      = !((ch_cnt_q == CH_LAST) && out_vld_q && bus.ff_full);
    wr           = out_vld_q && !bus.ff_full;
    acc          = bus.s_valid && s_ready;
    resync       = acc && bus.s_sof && (ch_cnt_q != '0);
    lanes_d      = lanes_q;
    out_d        = out_q;
    out_vld_d    = out_vld_q;
    ch_cnt_d     = ch_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = wr && (pix_cnt_q == PIX_LAST);
    sync_err_d   = resync;

    if (wr) begin
      out_vld_d = 1'b0;
      pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);
    end

    if (acc) begin
      if (resync) begin
        // Misaligned start of frame: drop the partial pixel, restart it from this sample.
        lanes_d[0] = bus.s_data;
        ch_cnt_d   = CW'(1);
      end else begin
        lanes_d[ch_cnt_q] = bus.s_data;
        if (ch_cnt_q == CH_LAST) begin
          ch_cnt_d  = '0;
          out_d     = lanes_d;
          out_vld_d = 1'b1;
        end else begin
          ch_cnt_d = ch_cnt_q + CW'(1);
        end
      end
      // Frame restart takes priority over a write landing in the same cycle.
      if (bus.s_sof) pix_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      lanes_q      <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      ch_cnt_q     <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      ch_cnt_q     <= ch_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.ff_wrreq   = wr;
  assign bus.ff_wdata   = out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: driver models accepted samples into an expected-word queue,
// a negedge monitor pops on every FIFO write and checks frame_done/sync_err timing.
module tb_pixel_packer;
  localparam int DW = 32, NC = 8, W = 56, H = 56, TOTAL = W * H;

  logic clk = 1'b0;
  logic resetn;

  pixel_packer_if #(.DWIDTH(DW), .NUM_CHANNEL_IN(NC)) bus ();
  pixel_packer #(.DWIDTH(DW), .NUM_CHANNEL_IN(NC), .WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [NC*DW-1:0] exp_q[$];
  logic [NC-1:0][DW-1:0] mdl_lanes;
  int   mdl_k   = 0;
  int   mon_pix = 0;
  logic exp_sync = 1'b0;
  logic exp_fd   = 1'b0;

  task automatic chk(input string name, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic sof, input logic [DW-1:0] d);
    if (sof) begin
      mon_pix = 0;
      if (mdl_k != 0) begin
        exp_sync = 1'b1;
        mdl_k    = 0;
      end
    end
    mdl_lanes[mdl_k] = d;
    mdl_k++;
    if (mdl_k == NC) begin
      exp_q.push_back(mdl_lanes);
      mdl_k = 0;
    end
  endtask

  // Entered and left at posedge+1; the presented inputs are accepted (or not) at the next posedge.
  task automatic cyc(input logic v, input logic s, input logic [DW-1:0] d, input logic f, output logic acc);
    bus.s_valid = v;
    bus.s_sof   = s;
    bus.s_data  = d;
    bus.ff_full = f;
    #2;
    acc = v && bus.s_ready;
    @(posedge clk);
    if (acc) model_accept(s, d);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        if (bus.sync_err || exp_sync) chk("sync_err", bus.sync_err, exp_sync);
        exp_sync = 1'b0;
        if (bus.frame_done || exp_fd) chk("frame_done", bus.frame_done, exp_fd);
        exp_fd = 1'b0;
        if (bus.ff_wrreq) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %h expected no write", bus.ff_wdata);
          end else begin
            chk("wdata", bus.ff_wdata, exp_q.pop_front());
          end
          mon_pix++;
          if (mon_pix == TOTAL) begin
            mon_pix = 0;
            exp_fd  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    logic [NC*DW-1:0] k_seq, k_a;
    k_seq = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    k_a   = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;
    bus.ff_full = 1'b0;
    resetn      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.s_ready, 1);
    chk("rst_wrreq", bus.ff_wrreq, 0);
    chk("rst_wdata", bus.ff_wdata, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    resetn = 1'b0;
    @(posedge clk);
    #1;

    // Eight ascending samples form one word, strobed one cycle after the last lane.
    for (int i = 1; i <= NC; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0, acc);
    chk("lat_wrreq", bus.ff_wrreq, 1);
    chk("lat_wdata", bus.ff_wdata, k_seq);
    repeat (2) cyc(1'b0, 1'b0, '0, 1'b0, acc);

    // FIFO full: pixel A pending, pixel B stalls at its last lane for 20 cycles.
    for (int i = 0; i < NC; i++) cyc(1'b1, 1'b0, DW'(32'hA0 + i), 1'b1, acc);
    for (int i = 0; i < NC - 1; i++) cyc(1'b1, 1'b0, DW'(32'hB0 + i), 1'b1, acc);
    for (int n = 0; n < 20; n++) begin
      cyc(1'b1, 1'b0, 32'hB7, 1'b1, acc);
      chk("stall_ready", acc, 0);
      chk("stall_wrreq", bus.ff_wrreq, 0);
      chk("stall_wdata", bus.ff_wdata, k_a);
    end
    cyc(1'b1, 1'b0, 32'hB7, 1'b0, acc);
    chk("release_accept", acc, 1);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, acc);

    // Reset with a pending pixel and four lanes of the next one.
    for (int i = 0; i < NC; i++) cyc(1'b1, 1'b0, DW'(32'hC0 + i), 1'b1, acc);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(32'hD0 + i), 1'b1, acc);
    bus.s_valid = 1'b0;
    bus.ff_full = 1'b0;
    resetn      = 1'b1;
    #1;
    chk("midrst_wrreq", bus.ff_wrreq, 0);
    chk("midrst_ready", bus.s_ready, 1);
    chk("midrst_wdata", bus.ff_wdata, 0);
    exp_q.delete();
    mdl_k    = 0;
    mon_pix  = 0;
    exp_sync = 1'b0;
    exp_fd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    for (int i = 0; i < NC; i++) cyc(1'b1, 1'b0, DW'(32'hE0 + i), 1'b0, acc);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, acc);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    // s_sof at lane 5 resyncs; that pixel starts a full frame of 3136 writes.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(32'hF0 + i), 1'b0, acc);
    cyc(1'b1, 1'b1, 32'h5AF0_0000, 1'b0, acc);
    for (int i = 1; i < NC; i++) cyc(1'b1, 1'b0, DW'(32'h5AF0_0000 + i), 1'b0, acc);
    for (int p = 1; p < TOTAL; p++)
      for (int c = 0; c < NC; c++) cyc(1'b1, 1'b0, DW'(p * 256 + c), 1'b0, acc);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, acc);

    // s_sof on lane 0 is a clean frame restart with no sync_err.
    for (int i = 0; i < 2 * NC; i++) cyc(1'b1, 1'b0, DW'(32'h7700 + i), 1'b0, acc);
    for (int i = 0; i < NC; i++) cyc(1'b1, (i == 0), DW'(32'h8800 + i), 1'b0, acc);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, acc);

    // Random valid/full traffic.
    for (int n = 0; n < 10000; n++)
      cyc(($urandom_range(0, 9) < 7), 1'b0, DW'($urandom), ($urandom_range(0, 9) < 3), acc);
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b0, acc);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
